// File: rtl/pwm_multi.sv
// Multi-channel PWM with edge/center-aligned counting.
// New mode/period/duty settings are held in a shadow and applied only at a period wrap.
module pwm_multi #(
   parameter int               CBITS      = 19,
   parameter int               NCH        = 4,
   parameter logic [CBITS-1:0] RST_PERIOD = {CBITS{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 mode,
   input  logic [CBITS-1:0]     period,
   input  logic [NCH*CBITS-1:0] duty,
   input  logic                 load,
   output logic [NCH-1:0]       pwm_out,
   output logic                 period_start,
   output logic                 upd_done
);

   logic [CBITS-1:0]     cnt;
   logic [CBITS-1:0]     cnt_nxt;
   logic                 dir;
   logic                 dir_nxt;
   logic [CBITS-1:0]     per_act;
   logic [CBITS-1:0]     per_sh;
   logic                 mode_act;
   logic                 mode_sh;
   logic [NCH*CBITS-1:0] duty_act;
   logic [NCH*CBITS-1:0] duty_sh;
   logic                 pend;
   logic                 wrap;
   logic                 apply;
   logic [NCH-1:0]       cmp;

   // dir = 1 means counting down; only center mode ever sets it
   always_comb begin
      wrap = 1'b0;
      if (per_act == '0)
         wrap = 1'b1;
      else if (!mode_act)
         wrap = (cnt == per_act);
      else
         wrap = (cnt == CBITS'(1)) && dir;
   end

   assign apply = pend && (wrap || !en);

   always_comb begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
      if (!en || wrap) begin
         cnt_nxt = '0;
         dir_nxt = 1'b0;
      end else if (!mode_act) begin
         cnt_nxt = cnt + CBITS'(1);
      end else if (!dir) begin
         cnt_nxt = cnt + CBITS'(1);
         dir_nxt = (cnt_nxt == per_act);
      end else begin
         cnt_nxt = cnt - CBITS'(1);
         dir_nxt = 1'b1;
      end
   end

   always_comb begin
      cmp = '0;
      for (int i = 0; i < NCH; i++)
         cmp[i] = (cnt < duty_act[i*CBITS +: CBITS]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         dir          <= 1'b0;
         per_act      <= RST_PERIOD;
         per_sh       <= RST_PERIOD;
         mode_act     <= 1'b0;
         mode_sh      <= 1'b0;
         duty_act     <= '0;
         duty_sh      <= '0;
         pend         <= 1'b0;
         pwm_out      <= '0;
         period_start <= 1'b0;
         upd_done     <= 1'b0;
      end else begin
         cnt          <= cnt_nxt;
         dir          <= dir_nxt;
         pwm_out      <= en ? cmp : '0;
         period_start <= en && (cnt == '0);
         upd_done     <= apply;
         if (apply) begin
            per_act  <= per_sh;
            mode_act <= mode_sh;
            duty_act <= duty_sh;
            pend     <= 1'b0;
         end
         // a load in the apply cycle re-arms pend for the next wrap
         if (load) begin
            per_sh  <= period;
            mode_sh <= mode;
            duty_sh <= duty;
            pend    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi (CBITS=8, NCH=2).
// Stimulus pushes hand-derived expected outputs; a negedge monitor pops and compares.
module tb_pwm_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        mode;
   logic [7:0]  period;
   logic [15:0] duty;
   logic        load;
   logic [1:0]  pwm_out;
   logic        period_start;
   logic        upd_done;

   typedef struct {
      int         stamp;
      int         scn;
      logic [1:0] pw;
      logic       ps;
      logic       ud;
   } exp_t;

   exp_t q[$];
   int   ncyc   = 0;
   int   nneg   = 0;
   int   errors = 0;
   int   checks = 0;
   int   cseq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

   pwm_multi #(.CBITS(8), .NCH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .period       (period),
      .duty         (duty),
      .load         (load),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .upd_done     (upd_done)
   );

   always #5 clk = ~clk;

   task automatic tick(input int scn, input logic [1:0] pw,
                       input logic ps, input logic ud);
      exp_t e;
      @(posedge clk);
      ncyc++;
      e.stamp = ncyc;
      e.scn   = scn;
      e.pw    = pw;
      e.ps    = ps;
      e.ud    = ud;
      q.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      nneg++;
      while (q.size() > 0 && q[0].stamp == nneg) begin
         e = q.pop_front();
         checks++;
         if ({pwm_out, period_start, upd_done} !== {e.pw, e.ps, e.ud}) begin
            errors++;
            $display("FAIL scn%0d cyc%0d got pwm=%b ps=%b ud=%b want pwm=%b ps=%b ud=%b",
                     e.scn, e.stamp, pwm_out, period_start, upd_done,
                     e.pw, e.ps, e.ud);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset overrides en and load
      rst = 1'b1; en = 1'b1; load = 1'b1;
      mode = 1'b1; period = 8'd5; duty = 16'h0505;
      tick(0, 2'b00, 1'b0, 1'b0);
      rst = 1'b0; en = 1'b0; load = 1'b0;
      tick(0, 2'b00, 1'b0, 1'b0);

      // edge P=9 duty {0,3}: loaded while parked, applied immediately
      load = 1'b1; mode = 1'b0; period = 8'd9; duty = {8'd0, 8'd3};
      tick(1, 2'b00, 1'b0, 1'b0);
      load = 1'b0;
      tick(1, 2'b00, 1'b0, 1'b1);
      en = 1'b1;
      for (int j = 0; j < 20; j++)
         tick(1, {1'b0, logic'((j % 10) < 3)}, logic'((j % 10) == 0), 1'b0);

      // mid-period duty 3 -> 7
      duty = {8'd0, 8'd7};
      for (int j = 0; j < 10; j++) begin
         load = (j == 4);
         tick(2, {1'b0, logic'(j < 3)}, logic'(j == 0), logic'(j == 9));
      end
      load = 1'b0;
      for (int j = 0; j < 10; j++)
         tick(2, {1'b0, logic'(j < 7)}, logic'(j == 0), 1'b0);

      // load in the wrap cycle applies one period later
      duty = {8'd0, 8'd2};
      for (int p = 0; p < 3; p++)
         for (int j = 0; j < 10; j++) begin
            load = (p == 0 && j == 9);
            tick(3, {1'b0, logic'(j < ((p == 2) ? 2 : 7))},
                 logic'(j == 0), logic'(p == 1 && j == 9));
         end
      load = 1'b0;

      // center P=4, ch0 duty 2, ch1 duty 5 (> P, constant high)
      mode = 1'b1; period = 8'd4; duty = {8'd5, 8'd2};
      for (int j = 0; j < 10; j++) begin
         load = (j == 0);
         tick(4, {1'b0, logic'(j < 2)}, logic'(j == 0), logic'(j == 9));
      end
      load = 1'b0;
      for (int j = 0; j < 16; j++)
         tick(4, {1'b1, logic'(cseq[j % 8] < 2)}, logic'(cseq[j % 8] == 0), 1'b0);

      // P=0 with ch0 duty 1 = P+1
      period = 8'd0; duty = {8'd0, 8'd1};
      for (int j = 0; j < 8; j++) begin
         load = (j == 0);
         tick(5, {1'b1, logic'(cseq[j] < 2)}, logic'(cseq[j] == 0), logic'(j == 7));
      end
      load = 1'b0;
      for (int j = 0; j < 4; j++)
         tick(5, 2'b01, 1'b1, 1'b0);

      // leave P=0 to edge P=3 duty {0,4}: load at a wrap applies next wrap
      mode = 1'b0; period = 8'd3; duty = {8'd0, 8'd4};
      load = 1'b1;
      tick(6, 2'b01, 1'b1, 1'b0);
      load = 1'b0;
      tick(6, 2'b01, 1'b1, 1'b1);
      for (int j = 0; j < 8; j++)
         tick(6, 2'b01, logic'((j % 4) == 0), 1'b0);

      // en=0 applies a pending shadow at once
      duty = {8'd0, 8'd2};
      tick(7, 2'b01, 1'b1, 1'b0);
      load = 1'b1;
      tick(7, 2'b01, 1'b0, 1'b0);
      load = 1'b0; en = 1'b0;
      tick(7, 2'b00, 1'b0, 1'b1);
      tick(7, 2'b00, 1'b0, 1'b0);
      en = 1'b1;
      for (int j = 0; j < 4; j++)
         tick(7, {1'b0, logic'(j < 2)}, logic'(j == 0), 1'b0);

      // reset mid-period with a pending update
      period = 8'd7; duty = {8'd3, 8'd3};
      tick(8, 2'b01, 1'b1, 1'b0);
      load = 1'b1;
      tick(8, 2'b01, 1'b0, 1'b0);
      rst = 1'b1;
      tick(8, 2'b00, 1'b0, 1'b0);
      rst = 1'b0; load = 1'b0;
      for (int j = 0; j < 5; j++)
         tick(8, 2'b00, logic'(j == 0), 1'b0);
      en = 1'b0;
      tick(8, 2'b00, 1'b0, 1'b0);
      en = 1'b1;
      for (int j = 0; j < 257; j++)
         tick(9, 2'b00, logic'((j % 256) == 0), 1'b0);

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter CBITS, default 19, counter/period/duty width in bits.
REQ-002 Parameter NCH, default 4, number of PWM channels (1..16).
REQ-003 Parameter RST_PERIOD, default 2**CBITS-1, active period loaded at reset.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  run enable; 0 = counter parked.
REQ-007 mode  input  1  0 = edge-aligned, 1 = center-aligned (captured on load).
REQ-008 period  input  CBITS  period value P (captured on load).
REQ-009 duty  input  NCH*CBITS  channel i duty in bits [i*CBITS +: CBITS] (captured on load).
REQ-010 load  input  1  one-cycle strobe; captures mode/period/duty into shadow registers.
REQ-011 pwm_out  output  NCH  registered PWM outputs.
REQ-012 period_start  output  1  registered one-cycle pulse marking counter value 0.
REQ-013 upd_done  output  1  registered one-cycle pulse when shadow values become active.

Function
REQ-014 Counter cnt (CBITS bits, unsigned) and direction flag dir (up/down) SHALL be internal registers.
REQ-015 Edge mode: cnt SHALL count 0,1,...,P_act, then 0; period length P_act+1 cycles; dir stays up.
REQ-016 Center mode: cnt SHALL count 0 up to P_act, then down to 1, then 0; period length 2*P_act cycles; dir flips in the cycle cnt reaches P_act (down) and 0 (up).
REQ-017 P_act = 0 in either mode: cnt SHALL remain 0; every cycle is a wrap cycle.
REQ-018 Wrap cycle: edge mode cnt == P_act; center mode cnt == 1 with dir down; the next cnt is 0.
REQ-019 pwm_out[i] SHALL equal (cnt < duty_act[i]), registered: cycle t+1 reflects cnt at cycle t.
REQ-020 duty_act[i] = 0 SHALL give constant 0; duty_act[i] > P_act SHALL give constant 1 (edge mode, and center mode).
REQ-021 period_start SHALL be (cnt == 0) registered, same one-cycle latency as pwm_out.
REQ-022 load = 1 SHALL write mode/period/duty into shadow registers and set the pending flag; a later load before application overwrites the shadow (last load wins).
REQ-023 At the clock edge ending a wrap cycle with pending set, active mode/period/duty SHALL take shadow values, pending SHALL clear, and cnt = 0 with dir up.
REQ-024 upd_done SHALL pulse high for exactly the one cycle following that application.
REQ-025 load asserted during a wrap cycle SHALL update the shadow, but the values SHALL apply at the following wrap, not the current one.
REQ-026 Mode change SHALL take effect only at a wrap; no partial or truncated periods occur on update.
REQ-027 en = 0 SHALL force cnt = 0 and dir up, and pwm_out = 0 and period_start = 0 from the next cycle; a pending shadow SHALL apply immediately (next edge), with upd_done pulsing.
REQ-028 en rising SHALL start counting from 0; first period_start one cycle after en goes high.
REQ-029 Arithmetic SHALL be unsigned CBITS-bit; cnt never exceeds P_act, so no overflow wrap is possible.

Reset
REQ-030 rst = 1 SHALL, at the next edge, set cnt = 0, dir up, active period = RST_PERIOD, active duty = 0, active mode = 0, shadow = active values, pending = 0.
REQ-031 Outputs after reset: pwm_out = 0, period_start = 0, upd_done = 0.
REQ-032 rst SHALL override en and load in the same cycle; reset mid-period abandons the period and discards pending updates.

Verification
REQ-033 CBITS=8, NCH=2, edge, P=9, duty={3,0}, en=1 -> period 10 cycles; ch0 high 3 of 10, ch1 constantly low, period_start every 10 cycles.
REQ-034 Center, P=4, duty ch0=2 -> cnt 0,1,2,3,4,3,2,1 repeats; ch0 high for cnt 0,1 and 1 (3 of 8 cycles), centered on cnt 0.
REQ-035 Mid-period load duty ch0 3->7 -> old duty holds to the wrap; upd_done pulses once; new duty from the next period_start.
REQ-036 load in the wrap cycle -> no update at that wrap; applied one full period later.
REQ-037 duty = P+1 and P=0 cases -> constant-high output; P=0 gives period_start every cycle.
REQ-038 rst asserted mid-period with pending set -> all outputs 0 next cycle, pending discarded, period RST_PERIOD.
